uart_mmio_bridge: RTL and testbench

//  Memory-mapped responder on the CPU data-memory bus (data_address / dm_read_en / dm_write_en).

---
 rtl/uart_mmio_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: CPU data-bus window onto the board UART.
// TX/RX byte FIFOs, each serviced by its own handshake FSM.
module uart_mmio_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          TX_DEPTH  = 4,
    parameter int          RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_address,
    input  logic        dm_read_en,
    input  logic        dm_write_en,
    input  logic [31:0] data_to_write,
    output logic        sel,
    output logic [31:0] data_read,
    output logic [7:0]  txdata,
    output logic        txclk,
    input  logic        txready,
    input  logic [7:0]  rxdata,
    output logic        rxclk,
    input  logic        rxready
);

    localparam int TXW  = $clog2(TX_DEPTH);
    localparam int TXCW = $clog2(TX_DEPTH + 1);
    localparam int RXW  = $clog2(RX_DEPTH);
    localparam int RXCW = $clog2(RX_DEPTH + 1);

    typedef enum logic [1:0] {
        TX_IDLE, TX_SETUP, TX_PULSE, TX_HOLD
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_ACK, RX_WAIT
    } rx_state_t;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;

    logic [7:0]      tx_mem [TX_DEPTH];
    logic [TXW-1:0]  tx_wp, tx_rp;
    logic [TXCW-1:0] tx_cnt;
    logic [7:0]      rx_mem [RX_DEPTH];
    logic [RXW-1:0]  rx_wp, rx_rp;
    logic [RXCW-1:0] rx_cnt;

    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push, tx_pop, tx_load, rx_push, rx_pop;
    logic        tx_drop;
    logic        wr_hit, rd_hit, both_hit;
    logic [1:0]  off;
    logic [31:0] rd_val;
    logic        unused;

    assign unused = ^{data_to_write[31:8], data_address[1:0]};

    assign sel      = (data_address[31:4] == BASE_ADDR[31:4]);
    assign off      = data_address[3:2];
    assign wr_hit   = sel & dm_write_en;
    assign rd_hit   = sel & dm_read_en & ~dm_write_en;
    assign both_hit = sel & dm_read_en & dm_write_en;

    assign tx_full  = (tx_cnt == TXCW'(TX_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == RXCW'(RX_DEPTH));
    assign rx_empty = (rx_cnt == '0);

    // Full-FIFO stores are dropped even if a pop lands in the same cycle.
    assign tx_push = wr_hit && (off == 2'd0) && !tx_full;
    assign rx_pop  = rd_hit && (off == 2'd1) && !rx_empty;

    // Load mux; status reflects FIFO state before this cycle's push/pop.
    always_comb begin
        rd_val = '0;
        case (off)
            2'd1: rd_val = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
            2'd2: rd_val = {27'd0, tx_drop, rx_full, !rx_empty,
                            tx_empty, tx_full};
            default: rd_val = '0;
        endcase
    end

    // Registered load data; holds until the next hit load.
    always_ff @(posedge clk) begin
        if (rst)           data_read <= '0;
        else if (both_hit) data_read <= '0;
        else if (rd_hit)   data_read <= rd_val;
    end

    // Sticky overflow flag, cleared by writing STATUS bit 4.
    always_ff @(posedge clk) begin
        if (rst)
            tx_drop <= 1'b0;
        else if (wr_hit && off == 2'd0 && tx_full)
            tx_drop <= 1'b1;
        else if (wr_hit && off == 2'd2 && data_to_write[4])
            tx_drop <= 1'b0;
    end

    // TX FIFO storage.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= data_to_write[7:0];
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TXW'(1);
            if (tx_pop)  tx_rp <= tx_rp + TXW'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + TXCW'(1);
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - TXCW'(1);
        end
    end

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rxdata;
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RXW'(1);
            if (rx_pop)  rx_rp <= rx_rp + RXW'(1);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + RXCW'(1);
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - RXCW'(1);
        end
    end

    // TX state register and latched output byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            txdata   <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_load) txdata <= tx_mem[tx_rp];
        end
    end

    // TX handshake: latch, settle, strobe+pop, recover.
    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        tx_pop  = 1'b0;
        txclk   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && txready) begin
                    tx_load = 1'b1;
                    tx_next = TX_SETUP;
                end
            end
            TX_SETUP: tx_next = TX_PULSE;
            TX_PULSE: begin
                txclk   = 1'b1;
                tx_pop  = 1'b1;
                tx_next = TX_HOLD;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // RX handshake: capture, ack, wait for rxready to drop.
    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        rxclk   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rxready && !rx_full) begin
                    rx_push = 1'b1;
                    rx_next = RX_ACK;
                end
            end
            RX_ACK: begin
                rxclk   = 1'b1;
                rx_next = RX_WAIT;
            end
            RX_WAIT: begin
                if (!rxready) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge: scoreboard bench for the UART MMIO bridge.
// Expected TX bytes, RX bytes and load data are queued and popped on output.
module tb_uart_mmio_bridge;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] TXD  = BASE + 32'h0;
    localparam logic [31:0] RXD  = BASE + 32'h4;
    localparam logic [31:0] STA  = BASE + 32'h8;
    localparam logic [31:0] RSV  = BASE + 32'hC;
    localparam logic [31:0] MISS = 32'hFFFE_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_address = '0;
    logic        dm_read_en = 1'b0;
    logic        dm_write_en = 1'b0;
    logic [31:0] data_to_write = '0;
    logic        sel;
    logic [31:0] data_read;
    logic [7:0]  txdata;
    logic        txclk;
    logic        txready = 1'b0;
    logic [7:0]  rxdata = '0;
    logic        rxclk;
    logic        rxready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int tx_pulses = 0;
    int rx_pulses = 0;
    logic prev_tx = 1'b0;
    logic prev_rx = 1'b0;

    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic [31:0] rd_q [$];

    uart_mmio_bridge dut (
        .clk(clk), .rst(rst),
        .data_address(data_address),
        .dm_read_en(dm_read_en),
        .dm_write_en(dm_write_en),
        .data_to_write(data_to_write),
        .sel(sel), .data_read(data_read),
        .txdata(txdata), .txclk(txclk), .txready(txready),
        .rxdata(rxdata), .rxclk(rxclk), .rxready(rxready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: strobes must be one cycle; TX bytes checked in order.
    always @(negedge clk) begin
        if (txclk) begin
            chk("txclk_width", prev_tx, 1'b0);
            tx_pulses++;
            if (tx_q.size() == 0) chk("tx_extra", tx_q.size(), 1);
            else chk("txdata", txdata, tx_q.pop_front());
        end
        if (rxclk) begin
            chk("rxclk_width", prev_rx, 1'b0);
            rx_pulses++;
            rx_q.push_back(rxdata);
        end
        prev_tx = txclk;
        prev_rx = rxclk;
    end

    // One bus cycle; if rd_chk, the expected load is queued and checked next cycle.
    task automatic bus(input string tag, input logic [31:0] a,
                       input logic w, input logic r, input logic [31:0] d,
                       input logic rd_chk, input logic [31:0] exp);
        @(negedge clk);
        data_address = a;
        dm_write_en = w;
        dm_read_en = r;
        data_to_write = d;
        if (rd_chk) rd_q.push_back(exp);
        @(negedge clk);
        dm_write_en = 1'b0;
        dm_read_en = 1'b0;
        if (rd_chk) chk(tag, data_read, rd_q.pop_front());
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
        bus(tag, a, 1'b0, 1'b1, 32'd0, 1'b1, exp);
    endtask

    task automatic rd_rx(input string tag);
        logic [31:0] e;
        e = (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'd0;
        rd(tag, RXD, e);
    endtask

    task automatic tx_store(input logic [7:0] b);
        if (tx_q.size() < 4) tx_q.push_back(b);
        bus("st", TXD, 1'b1, 1'b0, {24'hABCDEF, b}, 1'b0, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic got;
        int base;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_data_read", data_read, 32'd0);
        chk("rst_txdata", txdata, 8'd0);
        chk("rst_txclk", txclk, 1'b0);
        chk("rst_rxclk", rxclk, 1'b0);
        rst = 1'b0;

        // Register map basics
        rd("status_reset", STA, 32'h2);
        rd("txdata_read", TXD, 32'h0);
        rd("status_again", STA, 32'h2);
        bus("miss_rd", MISS, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0);
        chk("rd_hold", data_read, 32'h2);
        bus("both_hi", STA, 1'b1, 1'b1, 32'd0, 1'b1, 32'd0);
        rd("reserved", RSV, 32'h0);
        data_address = MISS;
        #1 chk("sel_miss", sel, 1'b0);
        data_address = STA;
        #1 chk("sel_hit", sel, 1'b1);
        bus("miss_st", BASE - 32'h10, 1'b1, 1'b0, 32'h99, 1'b0, 32'd0);
        rd("status_after_miss", STA, 32'h2);

        // Single byte TX latency
        txready = 1'b1;
        tx_store(8'h41);
        chk("tx_lat1", txclk, 1'b0);
        @(negedge clk);
        chk("tx_lat2", txclk, 1'b0);
        @(negedge clk);
        chk("tx_lat3", txclk, 1'b1);
        chk("tx_lat3_data", txdata, 8'h41);
        @(negedge clk);
        txready = 1'b0;
        rd("status_tx_done", STA, 32'h2);
        chk("txdata_held", txdata, 8'h41);

        // Overflow and burst drain
        for (int i = 0; i < 5; i++) tx_store(8'hA0 + 8'(i));
        rd("status_full_drop", STA, 32'h11);
        base = tx_pulses;
        txready = 1'b1;
        for (int k = 0; k < 60 && tx_pulses - base < 4; k++) @(negedge clk);
        repeat (8) @(negedge clk);
        chk("tx_burst_cnt", tx_pulses - base, 4);
        chk("tx_q_drained", tx_q.size(), 0);
        rd("status_drop_kept", STA, 32'h12);
        bus("clr_drop", STA, 1'b1, 1'b0, 32'h10, 1'b0, 32'd0);
        rd("status_drop_clr", STA, 32'h2);

        // Single RX byte
        base = rx_pulses;
        rxdata = 8'h5A;
        rxready = 1'b1;
        repeat (8) @(negedge clk);
        chk("rx_one_ack", rx_pulses - base, 1);
        rd("status_rx", STA, 32'h6);
        rxready = 1'b0;
        rd_rx("rx_5a");
        rd_rx("rx_empty");

        // RX backpressure
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rxdata = 8'hC0 + 8'(i);
            rxready = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 6 && !got; k++) begin
                @(negedge clk);
                if (rxclk) got = 1'b1;
            end
            chk("rx_ack", got, (i < 4));
            if (got) begin
                @(negedge clk);
                rxready = 1'b0;
            end
        end
        rd("status_rx_full", STA, 32'h0E);
        rd_rx("rx_c0");
        got = 1'b0;
        for (int k = 0; k < 2 && !got; k++) begin
            @(negedge clk);
            if (rxclk) got = 1'b1;
        end
        chk("rx5_ack", got, 1'b1);
        @(negedge clk);
        rxready = 1'b0;
        for (int i = 0; i < 4; i++) rd_rx("rx_drain");
        rd_rx("rx_drained");
        rd("status_rx_done", STA, 32'h2);

        // Reset during TX PULSE
        txready = 1'b0;
        tx_store(8'h11);
        tx_store(8'h22);
        txready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (txclk) got = 1'b1;
        end
        chk("tx_pulse_seen", got, 1'b1);
        rst = 1'b1;
        txready = 1'b0;
        @(negedge clk);
        chk("rst_tx_strobe", txclk, 1'b0);
        chk("rst_tx_data", txdata, 8'd0);
        rst = 1'b0;
        tx_q.delete();

        // Reset during RX ACK
        rxdata = 8'h77;
        rxready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (rxclk) got = 1'b1;
        end
        chk("rx_ack_seen", got, 1'b1);
        rst = 1'b1;
        rxready = 1'b0;
        @(negedge clk);
        chk("rst_rx_strobe", rxclk, 1'b0);
        rst = 1'b0;
        rx_q.delete();
        rd("status_after_rst", STA, 32'h2);
        rd_rx("rx_after_rst");
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
